ahb_grant_controller: RTL and testbench

//   Sequential grant stage of the AHB arbiter. Forwards master bus requests to the

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_burst_counter.sv | 43 ++++
 rtl/ahb_grant_controller.sv | 85 ++++++++
 tb/tb_ahb_grant_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB transfer/burst encodings and burst-length helper shared by the grant stage.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Undefined-length INCR counts as a single beat: it never holds the bus.
  function automatic logic [4:0] beat_len(input logic [2:0] burst);
    case (hburst_e'(burst))
      HBURST_WRAP4, HBURST_INCR4:   beat_len = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   beat_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beat_len = 5'd16;
      default:                      beat_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_counter.sv
// Tracks remaining beats of a fixed-length burst and flags when the bus must not move.
module ahb_burst_counter
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  output logic       burst_hold
);

  logic [4:0] beat_cnt_q;
  logic [4:0] beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (hready) begin
      case (htrans_e'(htrans))
        HTRANS_NONSEQ: beat_cnt_d = beat_len(hburst) - 5'd1;
        HTRANS_SEQ:    if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - 5'd1;
        HTRANS_IDLE:   beat_cnt_d = '0;
        default:       beat_cnt_d = beat_cnt_q;
      endcase
    end
  end

  // A NONSEQ that starts a multi-beat burst holds the bus in its own cycle,
  // before the counter has been loaded.
  always_comb begin
    burst_hold = (beat_cnt_q != '0) |
                 (hready & (htrans == HTRANS_NONSEQ) & (beat_len(hburst) > 5'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/ahb_grant_controller.sv
// Sequential grant stage of the AHB arbiter: owner, HGRANT, HMASTER and HMASTLOCK registers.
module ahb_grant_controller
  import ahb_pkg::*;
#(
  parameter int N              = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N-1:0]         HBUSREQ,
  input  logic [N-1:0]         HLOCK,
  input  logic                 HREADY,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HBURST,
  output logic [N-1:0]         arb_requests,
  input  logic [$clog2(N)-1:0] arb_grant_idx,
  input  logic                 arb_grant_valid,
  output logic [N-1:0]         HGRANT,
  output logic [$clog2(N)-1:0] HMASTER,
  output logic                 HMASTLOCK
);

  localparam int LOGN = $clog2(N);
  localparam logic [LOGN-1:0] PARK_IDX   = LOGN'(DEFAULT_MASTER);
  localparam logic [N-1:0]    PARK_GRANT = N'(1) << DEFAULT_MASTER;

  logic [LOGN-1:0] owner_q, owner_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [LOGN-1:0] master_q, master_d;
  logic            mastlock_q, mastlock_d;
  logic            burst_hold;
  logic            lock_hold;
  logic            rearb;

  assign arb_requests = HBUSREQ;

  ahb_burst_counter u_burst_counter (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .hready     (HREADY),
    .htrans     (HTRANS),
    .hburst     (HBURST),
    .burst_hold (burst_hold)
  );

  always_comb begin
    lock_hold = HLOCK[owner_q];
    rearb     = HREADY & ~burst_hold & ~lock_hold;

    owner_d = owner_q;
    if (rearb) begin
      owner_d = arb_grant_valid ? arb_grant_idx : PARK_IDX;
    end

    // Grant register mirrors the next owner so HGRANT is onehot(owner_q) after the edge.
    grant_d          = '0;
    grant_d[owner_d] = 1'b1;

    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (HREADY) begin
      master_d   = owner_q;
      mastlock_d = HLOCK[owner_q];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner_q    <= PARK_IDX;
      grant_q    <= PARK_GRANT;
      master_q   <= PARK_IDX;
      mastlock_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_grant_controller.sv
// Self-checking bench: directed vector table, burst/reset sequences, randomized run vs model.
module tb_ahb_grant_controller;

  localparam int N    = 4;
  localparam int LOGN = 2;
  localparam int DEF  = 0;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [N-1:0]    HBUSREQ;
  logic [N-1:0]    HLOCK;
  logic            HREADY;
  logic [1:0]      HTRANS;
  logic [2:0]      HBURST;
  logic [N-1:0]    arb_requests;
  logic [LOGN-1:0] arb_grant_idx;
  logic            arb_grant_valid;
  logic [N-1:0]    HGRANT;
  logic [LOGN-1:0] HMASTER;
  logic            HMASTLOCK;
  logic [LOGN-1:0] junk_idx;

  int total = 0;
  int bad   = 0;

  ahb_grant_controller #(.N(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .HBUSREQ         (HBUSREQ),
    .HLOCK           (HLOCK),
    .HREADY          (HREADY),
    .HTRANS          (HTRANS),
    .HBURST          (HBURST),
    .arb_requests    (arb_requests),
    .arb_grant_idx   (arb_grant_idx),
    .arb_grant_valid (arb_grant_valid),
    .HGRANT          (HGRANT),
    .HMASTER         (HMASTER),
    .HMASTLOCK       (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  // Fixed-priority arbiter beside the block: lowest index wins; junk index when idle.
  always_comb begin
    arb_grant_valid = |arb_requests;
    arb_grant_idx   = junk_idx;
    for (int i = N - 1; i >= 0; i--) begin
      if (arb_requests[i]) arb_grant_idx = LOGN'(i);
    end
  end

  // Reference model: plain integers describing who owns the bus and how many beats remain.
  int m_owner, m_master, m_beats;
  bit m_lock;

  function automatic int burst_beats(input logic [2:0] b);
    return (b < 3'd2) ? 1 : (2 << (b >> 1));
  endfunction

  task automatic model_update();
    int len, nxt;
    bit in_burst;
    if (!HRESETn) begin
      m_owner = DEF; m_master = DEF; m_lock = 0; m_beats = 0;
      return;
    end
    len      = burst_beats(HBURST);
    in_burst = (m_beats > 0) || (HREADY && HTRANS == 2'd2 && len > 1);
    nxt      = m_owner;
    if (HREADY && !in_burst && !HLOCK[m_owner]) begin
      nxt = DEF;
      for (int i = N - 1; i >= 0; i--) if (HBUSREQ[i]) nxt = i;
    end
    if (HREADY) begin
      m_master = m_owner;
      m_lock   = HLOCK[m_owner];
      case (HTRANS)
        2'd0: m_beats = 0;
        2'd2: m_beats = len - 1;
        2'd3: if (m_beats > 0) m_beats = m_beats - 1;
        default: ;
      endcase
    end
    m_owner = nxt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic [3:0] req, input logic [3:0] lk,
                      input logic rdy, input logic [1:0] tr, input logic [2:0] bu,
                      input bit vs_model);
    HRESETn = rn; HBUSREQ = req; HLOCK = lk; HREADY = rdy; HTRANS = tr; HBURST = bu;
    junk_idx = LOGN'($urandom);
    @(posedge HCLK);
    model_update();
    #1;
    chk("arb_requests", 32'(arb_requests), 32'(req));
    if (vs_model) begin
      chk("HGRANT",    32'(HGRANT),    32'(1 << m_owner));
      chk("HMASTER",   32'(HMASTER),   32'(m_master));
      chk("HMASTLOCK", 32'(HMASTLOCK), 32'(m_lock));
    end
  endtask

  typedef struct {
    logic       rn;
    logic [3:0] req;
    logic [3:0] lk;
    logic       rdy;
    logic [1:0] tr;
    logic [2:0] bu;
    logic [3:0] eg;
    logic [1:0] em;
    logic       el;
  } vec_t;

  vec_t vecs[16];

  initial begin
    HRESETn = 1'b0; HBUSREQ = '0; HLOCK = '0; HREADY = 1'b1;
    HTRANS = 2'd0; HBURST = 3'd0; junk_idx = '0;
    m_owner = DEF; m_master = DEF; m_lock = 0; m_beats = 0;

    //          rn  req      lk       rdy tr    bu    grant    mst   lock
    vecs[0]  = '{0, 4'b0000, 4'b0000, 1, 2'd0, 3'd0, 4'b0001, 2'd0, 0};
    vecs[1]  = '{1, 4'b0000, 4'b0000, 1, 2'd0, 3'd0, 4'b0001, 2'd0, 0};
    vecs[2]  = '{1, 4'b0100, 4'b0000, 1, 2'd0, 3'd0, 4'b0100, 2'd0, 0};
    vecs[3]  = '{1, 4'b0100, 4'b0000, 1, 2'd0, 3'd0, 4'b0100, 2'd2, 0};
    vecs[4]  = '{1, 4'b0010, 4'b0000, 1, 2'd2, 3'd3, 4'b0100, 2'd2, 0};
    vecs[5]  = '{1, 4'b0011, 4'b0000, 1, 2'd3, 3'd3, 4'b0100, 2'd2, 0};
    vecs[6]  = '{1, 4'b0011, 4'b0000, 1, 2'd3, 3'd3, 4'b0100, 2'd2, 0};
    vecs[7]  = '{1, 4'b0011, 4'b0000, 1, 2'd3, 3'd3, 4'b0100, 2'd2, 0};
    vecs[8]  = '{1, 4'b0011, 4'b0000, 1, 2'd0, 3'd0, 4'b0001, 2'd2, 0};
    vecs[9]  = '{1, 4'b0011, 4'b0000, 1, 2'd0, 3'd0, 4'b0001, 2'd0, 0};
    vecs[10] = '{1, 4'b1000, 4'b0000, 1, 2'd0, 3'd0, 4'b1000, 2'd0, 0};
    vecs[11] = '{1, 4'b1001, 4'b1000, 1, 2'd2, 3'd0, 4'b1000, 2'd3, 1};
    vecs[12] = '{1, 4'b1001, 4'b1000, 1, 2'd2, 3'd0, 4'b1000, 2'd3, 1};
    vecs[13] = '{1, 4'b0001, 4'b0000, 1, 2'd0, 3'd0, 4'b0001, 2'd3, 0};
    vecs[14] = '{1, 4'b0100, 4'b0000, 0, 2'd0, 3'd0, 4'b0001, 2'd3, 0};
    vecs[15] = '{1, 4'b0100, 4'b0000, 1, 2'd0, 3'd0, 4'b0100, 2'd0, 0};

    for (int v = 0; v < 16; v++) begin
      step(vecs[v].rn, vecs[v].req, vecs[v].lk, vecs[v].rdy, vecs[v].tr, vecs[v].bu, 1'b0);
      chk($sformatf("vec%0d HGRANT", v),    32'(HGRANT),    32'(vecs[v].eg));
      chk($sformatf("vec%0d HMASTER", v),   32'(HMASTER),   32'(vecs[v].em));
      chk($sformatf("vec%0d HMASTLOCK", v), 32'(HMASTLOCK), 32'(vecs[v].el));
    end

    // INCR8 owned by master 1, HREADY low for 3 cycles on beat 5.
    step(1, 4'b0010, 4'b0000, 1, 2'd0, 3'd0, 1'b1);
    step(1, 4'b0011, 4'b0000, 1, 2'd2, 3'd5, 1'b1);
    for (int b = 2; b <= 4; b++) step(1, 4'b0011, 4'b0000, 1, 2'd3, 3'd5, 1'b1);
    for (int s = 0; s < 3; s++) begin
      step(1, 4'b0011, 4'b0000, 0, 2'd3, 3'd5, 1'b1);
      chk("incr8 stall grant", 32'(HGRANT), 32'h2);
    end
    for (int b = 5; b <= 8; b++) begin
      step(1, 4'b0011, 4'b0000, 1, 2'd3, 3'd5, 1'b1);
      chk("incr8 beat grant", 32'(HGRANT), 32'h2);
    end
    step(1, 4'b0011, 4'b0000, 1, 2'd0, 3'd0, 1'b1);
    chk("incr8 handover", 32'(HGRANT), 32'h1);

    // Reset in the middle of an INCR16 owned by master 1 (beat_cnt reaches 9).
    step(1, 4'b0010, 4'b0000, 1, 2'd0, 3'd0, 1'b1);
    step(1, 4'b0010, 4'b0000, 1, 2'd2, 3'd7, 1'b1);
    for (int b = 0; b < 6; b++) step(1, 4'b0110, 4'b0000, 1, 2'd3, 3'd7, 1'b1);
    step(0, 4'b0100, 4'b0100, 1, 2'd3, 3'd7, 1'b1);
    chk("reset grant", 32'(HGRANT), 32'h1);
    chk("reset master", 32'(HMASTER), 32'h0);
    chk("reset lock", 32'(HMASTLOCK), 32'h0);
    step(1, 4'b0100, 4'b0000, 1, 2'd3, 3'd7, 1'b1);
    chk("post reset rearb", 32'(HGRANT), 32'h4);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [3:0] lk;
      lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(($urandom_range(0, 63) != 0), 4'($urandom), lk,
           ($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
